// File: rtl/ram_sp_param_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_sp_param_if
// Description : Access bus for ram_sp_param. The master drives rd/wr/add/data_in;
//               the RAM returns read data, read strobe, busy and address error.
// Revision    : 1.0
// ============================================================================
interface ram_sp_param_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
);
  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] add;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              busy;
  logic              addr_err;

  modport master (
    output wr, rd, add, data_in,
    input  data_out, rd_valid, busy, addr_err
  );

  modport slave (
    input  wr, rd, add, data_in,
    output data_out, rd_valid, busy, addr_err
  );
endinterface
`default_nettype wire

// File: rtl/ram_sp_param.sv
`default_nettype none
// ============================================================================
// Module      : ram_sp_param
// Description : Parametrised single-port synchronous RAM with registered read,
//               selectable read-during-write, range check and post-reset clear.
// Revision    : 1.0
// ============================================================================
module ram_sp_param #(
  parameter int                DATA_W   = 4,
  parameter int                ADDR_W   = 3,
  parameter int                DEPTH    = 8,
  parameter int                RD_MODE  = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  ram_sp_param_if.slave bus
);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  state_t            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DATA_W-1:0] data_out_q;
  logic              rd_valid_q;
  logic              busy_q;
  logic              addr_err_q;

  logic              w_in_range;
  logic [DATA_W-1:0] w_rdata;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_full_range
      assign w_in_range = 1'b1;
    end else begin : g_part_range
      assign w_in_range = ({1'b0, bus.add} < (ADDR_W + 1)'(DEPTH));
    end
  endgenerate

  // Read-first sees the pre-edge array contents; write-first forwards data_in.
  generate
    if (RD_MODE != 0) begin : g_write_first
      assign w_rdata = bus.wr ? bus.data_in : mem_q[bus.add];
    end else begin : g_read_first
      assign w_rdata = mem_q[bus.add];
    end
  endgenerate

  always_comb begin
    w_we    = 1'b0;
    w_waddr = ptr_q;
    w_wdata = INIT_VAL;
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        w_we = 1'b1;
      end else if (bus.wr && w_in_range) begin
        w_we    = 1'b1;
        w_waddr = bus.add;
        w_wdata = bus.data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      mem_q[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      ptr_q      <= '0;
      busy_q     <= 1'b1;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == C_LAST) begin
            state_q <= S_READY;
            busy_q  <= 1'b0;
          end
        end
        S_READY: begin
          addr_err_q <= (bus.rd | bus.wr) & ~w_in_range;
          if (bus.rd) begin
            rd_valid_q <= 1'b1;
            data_out_q <= w_in_range ? w_rdata : '0;
          end
        end
      endcase
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;
  assign bus.addr_err = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_sp_param
// Description : Directed bench for ram_sp_param: 16-word read-first, 16-word
//               write-first and 10-word read-first instances on one stimulus.
// Revision    : 1.0
// ============================================================================
module tb_ram_sp_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic       rd;
  logic [3:0] add;
  logic [7:0] din;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_sp_param_if #(.DATA_W(8), .ADDR_W(4)) ifa ();
  ram_sp_param_if #(.DATA_W(8), .ADDR_W(4)) ifb ();
  ram_sp_param_if #(.DATA_W(8), .ADDR_W(4)) ifc ();

  assign ifa.wr = wr;  assign ifa.rd = rd;  assign ifa.add = add;  assign ifa.data_in = din;
  assign ifb.wr = wr;  assign ifb.rd = rd;  assign ifb.add = add;  assign ifb.data_in = din;
  assign ifc.wr = wr;  assign ifc.rd = rd;  assign ifc.add = add;  assign ifc.data_in = din;

  ram_sp_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_MODE(0), .INIT_VAL(8'hA5))
    u_a (.clk(clk), .rst(rst), .bus(ifa));
  ram_sp_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_MODE(1), .INIT_VAL(8'hA5))
    u_b (.clk(clk), .rst(rst), .bus(ifb));
  ram_sp_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(10), .RD_MODE(0), .INIT_VAL(8'hA5))
    u_c (.clk(clk), .rst(rst), .bus(ifc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts busy cycles per instance; rd/wr held high at add 3 for the first 8 cycles.
  task automatic count_clear(input bit poke, output int ca, output int cb, output int cc,
                             output int bad);
    ca = 0; cb = 0; cc = 0; bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 8) begin wr = 1'b0; rd = 1'b0; end
      if (ifa.busy) begin ca++; if (ifa.rd_valid || ifa.addr_err) bad++; end
      if (ifb.busy) begin cb++; if (ifb.rd_valid || ifb.addr_err) bad++; end
      if (ifc.busy) begin cc++; if (ifc.rd_valid || ifc.addr_err) bad++; end
      if (!ifa.busy && !ifb.busy && !ifc.busy) break;
      tick();
    end
    if (poke) begin wr = 1'b0; rd = 1'b0; end
  endtask

  initial begin
    int ca, cb, cc, bad;
    logic [7:0] exp_c;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; add = '0; din = '0;
    tick();
    tick();
    check("rst_busy",     {7'd0, ifa.busy},     8'h01);
    check("rst_data_out", ifa.data_out,         8'h00);
    check("rst_rd_valid", {7'd0, ifa.rd_valid}, 8'h00);
    check("rst_addr_err", {7'd0, ifc.addr_err}, 8'h00);

    // Clear with attempted accesses that must be ignored
    rst = 1'b0; wr = 1'b1; rd = 1'b1; add = 4'd3; din = 8'h11;
    count_clear(1'b1, ca, cb, cc, bad);
    check("clear_len_a16", 8'(ca), 8'd16);
    check("clear_len_b16", 8'(cb), 8'd16);
    check("clear_len_c10", 8'(cc), 8'd10);
    check("no_pulse_busy", 8'(bad), 8'd0);

    for (int a = 0; a < 16; a++) begin
      rd = 1'b1; add = 4'(a);
      tick();
      check($sformatf("init_a_%0d", a), ifa.data_out, 8'hA5);
      check($sformatf("init_vld_%0d", a), {7'd0, ifa.rd_valid}, 8'h01);
      check($sformatf("init_b_%0d", a), ifb.data_out, 8'hA5);
      if (a < 10) check($sformatf("init_c_%0d", a), ifc.data_out, 8'hA5);
    end
    rd = 1'b0;
    tick();
    check("idle_vld", {7'd0, ifa.rd_valid}, 8'h00);

    // Write then read latency
    wr = 1'b1; add = 4'd5; din = 8'h3C;
    tick();
    check("wr_no_vld", {7'd0, ifa.rd_valid}, 8'h00);
    wr = 1'b0; rd = 1'b1;
    tick();
    check("rd5_a",   ifa.data_out,         8'h3C);
    check("rd5_vld", {7'd0, ifa.rd_valid}, 8'h01);
    check("rd5_c",   ifc.data_out,         8'h3C);
    rd = 1'b0;
    tick();
    check("hold_data", ifa.data_out,         8'h3C);
    check("hold_vld",  {7'd0, ifa.rd_valid}, 8'h00);

    // Read during write
    wr = 1'b1; add = 4'd7; din = 8'h01;
    tick();
    rd = 1'b1; din = 8'hFE;
    tick();
    check("rdw_read_first_a",  ifa.data_out, 8'h01);
    check("rdw_write_first_b", ifb.data_out, 8'hFE);
    check("rdw_read_first_c",  ifc.data_out, 8'h01);
    wr = 1'b0;
    tick();
    check("rdw_after_a", ifa.data_out, 8'hFE);
    check("rdw_after_b", ifb.data_out, 8'hFE);

    // Out-of-range accesses on the 10-word instance
    rd = 1'b0; wr = 1'b1; add = 4'd12; din = 8'h77;
    tick();
    check("oor_wr_err", {7'd0, ifc.addr_err}, 8'h01);
    check("oor_wr_vld", {7'd0, ifc.rd_valid}, 8'h00);
    wr = 1'b0; rd = 1'b1;
    tick();
    check("oor_rd_data", ifc.data_out,         8'h00);
    check("oor_rd_vld",  {7'd0, ifc.rd_valid}, 8'h01);
    check("oor_rd_err",  {7'd0, ifc.addr_err}, 8'h01);
    add = 4'd9;
    tick();
    check("rd9_err",  {7'd0, ifc.addr_err}, 8'h00);
    check("rd9_data", ifc.data_out,         8'hA5);
    for (int a = 0; a < 10; a++) begin
      add = 4'(a);
      tick();
      exp_c = (a == 5) ? 8'h3C : (a == 7) ? 8'hFE : 8'hA5;
      check($sformatf("oor_intact_c_%0d", a), ifc.data_out, exp_c);
    end
    rd = 1'b0;
    tick();
    check("idle_err", {7'd0, ifc.addr_err}, 8'h00);

    // Reset mid-clear restarts the sequence
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_clear(1'b0, ca, cb, cc, bad);
    check("reclear_len_a16", 8'(ca), 8'd16);
    check("reclear_len_c10", 8'(cc), 8'd10);
    for (int a = 0; a < 16; a++) begin
      rd = 1'b1; add = 4'(a);
      tick();
      check($sformatf("reclear_a_%0d", a), ifa.data_out, 8'hA5);
      if (a < 10) check($sformatf("reclear_c_%0d", a), ifc.data_out, 8'hA5);
    end
    rd = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
